// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices, FSM
// state encoding, the NOP instruction word and the load-use hazard test.
package pipe_ctrl_pkg;

    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_ALU    = 2;
    localparam int ST_MEM    = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        IC_WAIT  = 2'd2,
        DC_WAIT  = 2'd3
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Address compares are done by the caller so this stays width-agnostic.
    function automatic logic load_use_hazard(
        input logic id_valid,
        input logic use_a,
        input logic use_b,
        input logic match_a,
        input logic match_b,
        input logic ex_load,
        input logic ex_wb,
        input logic rd_nonzero
    );
        return id_valid & ex_load & ex_wb & rd_nonzero &
               ((use_a & match_a) | (use_b & match_b));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush arbiter for NUM_STAGES pipeline registers: load-use interlock,
// branch wrong-path flush, I/D-cache blocking and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int BRANCH_SLOTS = 2,
    parameter int CNT_W        = 32,
    parameter int INSTR_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_rs_a,
    input  logic [REG_W-1:0]      id_rs_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  ex_mem_r_en,
    input  logic                  ex_wb_en,
    input  logic                  ex_branch_taken,
    input  logic                  block_pipe_instr_cache,
    input  logic                  block_pipe_data_cache,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [INSTR_W-1:0]    inject_nop,
    output logic                  injecting_nop,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [NUM_STAGES-1:0] EN_ALL  = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] EN_LU   = EN_ALL << 2;
    localparam logic [NUM_STAGES-1:0] EN_IC   = EN_ALL << 1;
    localparam logic [NUM_STAGES-1:0] FL_LU   = NUM_STAGES'(1) << ST_ALU;
    localparam logic [NUM_STAGES-1:0] FL_IC   = NUM_STAGES'(1) << ST_DECODE;
    localparam logic [NUM_STAGES-1:0] FL_BR   = ~(EN_ALL << BRANCH_SLOTS);
    localparam logic [2:0]            LU_INIT = 3'(LOAD_LATENCY - 1);
    localparam bit                    LU_MULTI = (LOAD_LATENCY > 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_e state_q, state_d;
    ctrl_state_e ret_q, ret_d;
    ctrl_state_e eff_state;
    logic [2:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic        hazard;
    logic        any_stall;

    assign hazard = load_use_hazard(id_valid, id_use_a, id_use_b,
                                    id_rs_a == ex_rd, id_rs_b == ex_rd,
                                    ex_mem_r_en, ex_wb_en, ex_rd != '0);

    // After a D-cache block releases, resume whatever the block interrupted.
    assign eff_state = (state_q == DC_WAIT) ? ret_q : state_q;

    always_comb begin
        stage_en      = EN_ALL;
        stage_flush   = '0;
        injecting_nop = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ret_d         = ret_q;

        if (block_pipe_data_cache) begin
            stage_en = '0;
            state_d  = DC_WAIT;
            if (state_q != DC_WAIT) begin
                ret_d = (state_q == LU_STALL) ? LU_STALL : RUN;
            end
        end else if (eff_state == LU_STALL) begin
            stage_en      = EN_LU;
            stage_flush   = FL_LU;
            injecting_nop = 1'b1;
            cnt_d         = cnt_q - 3'd1;
            state_d       = (cnt_q == 3'd1) ? RUN : LU_STALL;
        end else if (ex_branch_taken) begin
            stage_en           = EN_ALL;
            stage_en[ST_FETCH] = ~block_pipe_instr_cache;
            stage_flush        = FL_BR;
            state_d            = eff_state;
        end else if (hazard) begin
            stage_en      = EN_LU;
            stage_flush   = FL_LU;
            injecting_nop = 1'b1;
            if (LU_MULTI) begin
                state_d = LU_STALL;
                cnt_d   = LU_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (block_pipe_instr_cache) begin
            stage_en      = EN_IC;
            stage_flush   = FL_IC;
            injecting_nop = 1'b1;
            state_d       = IC_WAIT;
        end else begin
            state_d = RUN;
        end

        if (reset) begin
            stage_en      = EN_ALL;
            stage_flush   = '0;
            injecting_nop = 1'b0;
        end
    end

    assign any_stall = ~&stage_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= 3'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            if (any_stall && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign inject_nop   = INSTR_W'(NOP_INSTR);
    assign state        = state_q;
    assign stall_cycles = stall_q;

endmodule
